paicore_recv_ctrl: RTL and testbench

Sequencing controller for the PAICORE receive datapath (join, transport_up, padding, output FIFO). It arms a receive session on software start and counts core output frames. It decides when the core has finished emitting, using a frame-count target or an idle timeout after the TX side completes. It then drives the recv_done/recv_busy/rx_rcving controls, waits for the datapath's rx_done, and reports completion and status.

---
 rtl/paicore_recv_ctrl.sv | 152 +++++++++++++++
 tb/tb_paicore_recv_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/paicore_recv_ctrl.sv
// Receive-side sequencing controller for PAICORE: arms a session, counts core output
// frames, decides end of emission (count target or idle timeout) and supervises the flush.
module paicore_recv_ctrl #(
    parameter int IDLE_W  = 16,
    parameter int FLUSH_W = 20,
    parameter int CNT_W   = 32
) (
    input  logic               m_axis_aclk,
    input  logic               m_axis_aresetn,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_tx_done,
    input  logic [CNT_W-1:0]   oFrameNumMax,
    input  logic [IDLE_W-1:0]  i_idle_cycles,
    input  logic [FLUSH_W-1:0] i_flush_cycles,
    input  logic               snn_out_hsked,
    input  logic               read_hsked,
    input  logic               i_rx_done,
    output logic               o_recv_busy,
    output logic               o_rx_rcving,
    output logic               o_recv_done,
    output logic               o_session_done,
    output logic [CNT_W-1:0]   o_frame_cnt,
    output logic [CNT_W-1:0]   o_read_cnt,
    output logic               o_err_flush_to,
    output logic [2:0]         o_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;

    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [IDLE_W-1:0]  IDLE_ONE  = {{(IDLE_W-1){1'b0}}, 1'b1};
    localparam logic [IDLE_W-1:0]  IDLE_MAX  = '1;
    localparam logic [FLUSH_W:0]   FLUSH_ONE = {{FLUSH_W{1'b0}}, 1'b1};
    localparam logic [FLUSH_W-1:0] WD_ONE    = {{(FLUSH_W-1){1'b0}}, 1'b1};

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   frame_q, frame_d, read_q, read_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [FLUSH_W-1:0] wd_q, wd_d;
    logic               tx_seen_q, tx_seen_d;
    logic               err_q, err_d;
    logic               recv_done_q, sess_done_q;

    logic [CNT_W:0]     frame_sum;
    logic [IDLE_W-1:0]  idle_thr;
    logic               count_hit, idle_hit, wd_hit, cnt_en;

    always_comb begin
        // frame count including a handshake landing this cycle
        frame_sum = {1'b0, frame_q} + {{CNT_W{1'b0}}, snn_out_hsked};
        idle_thr  = (i_idle_cycles == '0) ? IDLE_ONE : i_idle_cycles;
        count_hit = (oFrameNumMax != '0) && (frame_sum >= {1'b0, oFrameNumMax});
        idle_hit  = tx_seen_q && !snn_out_hsked && (idle_q >= idle_thr);
        wd_hit    = (i_flush_cycles != '0) &&
                    (({1'b0, wd_q} + FLUSH_ONE) >= {1'b0, i_flush_cycles});
        cnt_en    = ((state_q == S_RECV) || (state_q == S_FLUSH)) && !i_abort;

        state_d   = state_q;
        frame_d   = frame_q;
        read_d    = read_q;
        idle_d    = idle_q;
        wd_d      = wd_q;
        tx_seen_d = tx_seen_q;
        err_d     = err_q;

        if (cnt_en) begin
            if (snn_out_hsked && (frame_q != CNT_MAX)) frame_d = frame_q + CNT_ONE;
            if (read_hsked && (read_q != CNT_MAX))     read_d  = read_q + CNT_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    state_d   = S_RECV;
                    frame_d   = '0;
                    read_d    = '0;
                    idle_d    = '0;
                    tx_seen_d = 1'b0;
                    err_d     = 1'b0;
                end
            end
            S_RECV: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (i_tx_done) tx_seen_d = 1'b1;
                    if (snn_out_hsked)                        idle_d = '0;
                    else if (tx_seen_q && (idle_q != IDLE_MAX)) idle_d = idle_q + IDLE_ONE;
                    if (count_hit || idle_hit) begin
                        state_d = S_FLUSH;
                        wd_d    = '0;
                    end
                end
            end
            S_FLUSH: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + WD_ONE;
                    // rx_done takes priority over a simultaneous watchdog expiry
                    if (i_rx_done) begin
                        state_d = S_DONE;
                    end else if (wd_hit) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            read_q      <= '0;
            idle_q      <= '0;
            wd_q        <= '0;
            tx_seen_q   <= 1'b0;
            err_q       <= 1'b0;
            recv_done_q <= 1'b0;
            sess_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            read_q      <= read_d;
            idle_q      <= idle_d;
            wd_q        <= wd_d;
            tx_seen_q   <= tx_seen_d;
            err_q       <= err_d;
            recv_done_q <= (state_q == S_RECV) && (state_d == S_FLUSH);
            sess_done_q <= (state_q == S_FLUSH) && (state_d == S_DONE);
        end
    end

    assign o_recv_busy    = (state_q == S_RECV) || (state_q == S_FLUSH);
    assign o_rx_rcving    = (state_q == S_RECV);
    assign o_recv_done    = recv_done_q;
    assign o_session_done = sess_done_q;
    assign o_frame_cnt    = frame_q;
    assign o_read_cnt     = read_q;
    assign o_err_flush_to = err_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_paicore_recv_ctrl.sv
// Bench for paicore_recv_ctrl: directed scenarios plus random traffic, every cycle
// compared against a session-level reference model.
module tb_paicore_recv_ctrl;
    localparam int IDLE_W  = 16;
    localparam int FLUSH_W = 20;
    localparam int CNT_W   = 8;
    localparam longint CMAX = (64'd1 << CNT_W) - 1;
    localparam longint IMAX = (64'd1 << IDLE_W) - 1;

    logic clk = 1'b0;
    logic rstn, start, abort, txd, hs, rd, rxd;
    logic [CNT_W-1:0]   fmax;
    logic [IDLE_W-1:0]  idlec;
    logic [FLUSH_W-1:0] flushc;
    logic               busy, rcving, recv_done, sess_done, err;
    logic [CNT_W-1:0]   frame_cnt, read_cnt;
    logic [2:0]         state;

    int checks = 0;
    int errors = 0;

    // reference model: session phase and counters
    int     m_st;
    longint m_fc, m_rc, m_idle, m_wd;
    bit     m_tx, m_err, m_rdone, m_sdone;

    always #5 clk = ~clk;

    paicore_recv_ctrl #(.IDLE_W(IDLE_W), .FLUSH_W(FLUSH_W), .CNT_W(CNT_W)) dut (
        .m_axis_aclk(clk), .m_axis_aresetn(rstn), .i_start(start), .i_abort(abort),
        .i_tx_done(txd), .oFrameNumMax(fmax), .i_idle_cycles(idlec),
        .i_flush_cycles(flushc), .snn_out_hsked(hs), .read_hsked(rd), .i_rx_done(rxd),
        .o_recv_busy(busy), .o_rx_rcving(rcving), .o_recv_done(recv_done),
        .o_session_done(sess_done), .o_frame_cnt(frame_cnt), .o_read_cnt(read_cnt),
        .o_err_flush_to(err), .o_state(state));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step();
        longint thr;
        bit     leave;
        m_rdone = 0;
        m_sdone = 0;
        if (!rstn) begin
            m_st = 0; m_fc = 0; m_rc = 0; m_idle = 0; m_wd = 0; m_tx = 0; m_err = 0;
            return;
        end
        if (m_st != 0 && abort) begin
            m_st = 0;
            return;
        end
        if (m_st == 0) begin
            if (start && !abort) begin
                m_st = 1; m_fc = 0; m_rc = 0; m_idle = 0; m_tx = 0; m_err = 0;
            end
        end else if (m_st == 1) begin
            thr   = (idlec == 0) ? 1 : longint'(idlec);
            leave = (fmax != 0 && (m_fc + hs) >= fmax) || (m_tx && !hs && m_idle >= thr);
            m_idle = hs ? 0 : (m_tx ? sat(m_idle + 1, IMAX) : m_idle);
            if (txd) m_tx = 1;
            m_fc = sat(m_fc + hs, CMAX);
            m_rc = sat(m_rc + rd, CMAX);
            if (leave) begin m_st = 2; m_wd = 0; m_rdone = 1; end
        end else if (m_st == 2) begin
            m_fc = sat(m_fc + hs, CMAX);
            m_rc = sat(m_rc + rd, CMAX);
            if (rxd) begin
                m_st = 3; m_sdone = 1;
            end else if (flushc != 0 && m_wd + 1 >= flushc) begin
                m_st = 3; m_sdone = 1; m_err = 1;
            end
            m_wd++;
        end else begin
            m_st = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("state", state, m_st);
        chk("busy", busy, (m_st == 1 || m_st == 2));
        chk("rcving", rcving, (m_st == 1));
        chk("recv_done", recv_done, m_rdone);
        chk("session_done", sess_done, m_sdone);
        chk("frame_cnt", frame_cnt, m_fc);
        chk("read_cnt", read_cnt, m_rc);
        chk("err_flush_to", err, m_err);
        start = 0; abort = 0; txd = 0; hs = 0; rd = 0; rxd = 0;
    endtask

    task automatic run_to_idle(input int bound);
        int n = 0;
        while (m_st != 0 && n < bound) begin tick(); n++; end
        chk("idle_timeout", (m_st == 0), 1);
    endtask

    int pulses;

    initial begin
        rstn = 0; start = 0; abort = 0; txd = 0; hs = 0; rd = 0; rxd = 0;
        fmax = 0; idlec = 10; flushc = 0;
        m_st = 0; m_fc = 0; m_rc = 0; m_idle = 0; m_wd = 0; m_tx = 0; m_err = 0;
        @(negedge clk);
        repeat (3) tick();
        chk("reset_state", state, 0);
        chk("reset_frame", frame_cnt, 0);
        rstn = 1;
        tick();

        // count-target exit
        fmax = 4; flushc = 0;
        start = 1; tick();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            hs = 1; tick(); pulses += recv_done;
            tick(); pulses += recv_done;
            tick(); pulses += recv_done;
        end
        repeat (2) begin tick(); pulses += recv_done; end
        rxd = 1; tick();
        chk("count_sess_done", sess_done, 1);
        chk("count_recv_pulses", pulses, 1);
        chk("count_frames", frame_cnt, 4);
        tick();
        chk("count_back_idle", state, 0);

        // idle-timeout exit with a restart mid-silence
        fmax = 0; idlec = 10;
        start = 1; tick();
        for (int i = 0; i < 3; i++) begin hs = 1; tick(); tick(); end
        txd = 1; tick();
        repeat (6) tick();
        hs = 1; tick();
        pulses = 0;
        for (int i = 0; i < 30 && pulses == 0; i++) begin tick(); pulses += recv_done; end
        chk("idle_recv_done", pulses, 1);
        rxd = 1; tick();
        run_to_idle(5);

        // flush watchdog expiry, then rx_done on the expiry cycle
        fmax = 1; flushc = 8;
        start = 1; tick();
        hs = 1; tick();
        run_to_idle(20);
        chk("wd_err_set", err, 1);
        start = 1; tick();
        hs = 1; tick();
        repeat (7) tick();
        rxd = 1; tick();
        chk("wd_rx_wins", err, 0);
        chk("wd_rx_sess", sess_done, 1);
        tick();

        // abort mid-RECV
        fmax = 0; flushc = 0;
        start = 1; tick();
        hs = 1; tick(); hs = 1; tick();
        abort = 1; tick();
        chk("abort_state", state, 0);
        chk("abort_hold", frame_cnt, 2);
        start = 1; tick();
        chk("abort_restart_clr", frame_cnt, 0);
        abort = 1; tick();

        // reset in FLUSH, start ignored while held
        fmax = 1;
        start = 1; tick();
        hs = 1; tick(); tick(); tick();
        rstn = 0; start = 1; tick();
        chk("rst_flush_state", state, 0);
        rstn = 1; start = 1; tick();
        chk("rst_start_ok", state, 1);
        abort = 1; tick();

        // counter saturation
        fmax = 0;
        start = 1; tick();
        for (int i = 0; i < 260; i++) begin hs = 1; rd = 1; tick(); end
        chk("sat_frame", frame_cnt, CMAX);
        chk("sat_read", read_cnt, CMAX);
        abort = 1; tick();

        // ignore rules: tx_done in IDLE, start in RECV
        idlec = 1;
        txd = 1; tick();
        start = 1; tick();
        start = 1; tick();
        repeat (20) tick();
        chk("ignore_still_recv", state, 1);
        abort = 1; tick();

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            if (m_st == 0 && $urandom_range(7) == 0) begin
                fmax   = CNT_W'($urandom_range(6));
                idlec  = IDLE_W'($urandom_range(5));
                flushc = FLUSH_W'($urandom_range(12));
            end
            rstn  = ($urandom_range(199) != 0);
            start = ($urandom_range(5) == 0);
            abort = ($urandom_range(49) == 0);
            txd   = ($urandom_range(14) == 0);
            hs    = ($urandom_range(2) == 0);
            rd    = ($urandom_range(2) == 0);
            rxd   = ($urandom_range(9) == 0);
            tick();
        end
        rstn = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
